// File: rtl/nrn_pkg.sv
// rtl/nrn_pkg.sv - shared types and constants for the neuron bank driver
package nrn_pkg;

  localparam int SETTLE_MAX = 255;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } nrn_state_t;

endpackage

// File: rtl/nrn_settle_counter.sv
// rtl/nrn_settle_counter.sv - loadable down-counter with zero flag for the settle window
module nrn_settle_counter
  import nrn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/neuron_bank_driver.sv
// rtl/neuron_bank_driver.sv - drives a threshold neuron bank and captures its outputs
// Optional result parity output enabled by NRN_DRV_PARITY_EN.
module neuron_bank_driver
  import nrn_pkg::*;
#(
  parameter int CONNECTIONS = 2,
  parameter int NEURONS     = 4,
  parameter int SETTLE      = 1
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CONNECTIONS-1:0] in_data,
  output logic                   nrn_enable,
  output logic [CONNECTIONS-1:0] nrn_in,
  input  logic [NEURONS-1:0]     nrn_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NEURONS-1:0]     res_data,
  output logic                   busy
`ifdef NRN_DRV_PARITY_EN
  ,
  output logic                   res_parity
`endif
);

  if ((SETTLE < 1) || (SETTLE > SETTLE_MAX)) begin : g_settle_range
    $error("neuron_bank_driver: SETTLE must be within 1..255");
  end

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  nrn_state_t state, state_next;
  logic       accept;
  logic       capture;
  logic       cnt_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_zero) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter holds SETTLE-1 after accept, so capture lands SETTLE edges later.
  nrn_settle_counter u_settle (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (SETTLE_LOAD),
    .dec        (state == DRIVE),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      nrn_in   <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        nrn_in <= in_data;
      end
      if (capture) begin
        res_data <= nrn_out;
      end
    end
  end

`ifdef NRN_DRV_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      res_parity <= 1'b0;
    end else if (capture) begin
      res_parity <= ^nrn_out;
    end
  end
`endif

  assign in_ready   = (state == IDLE);
  assign nrn_enable = (state == DRIVE);
  assign res_valid  = (state == HOLD);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_neuron_bank_driver.sv
// tb/tb_neuron_bank_driver.sv - self-checking bench for neuron_bank_driver
module tb_neuron_bank_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid1 = 1'b0, in_ready1, nrn_en1, res_valid1, res_ready1 = 1'b0, busy1;
  logic [1:0] in_data1 = '0, nrn_in1;
  logic [3:0] nrn_out1, res_data1;

  logic       in_valid5 = 1'b0, in_ready5, nrn_en5, res_valid5, res_ready5 = 1'b0, busy5;
  logic [1:0] in_data5 = '0, nrn_in5;
  logic [3:0] nrn_out5 = '0, res_data5;

`ifdef NRN_DRV_PARITY_EN
  logic res_parity1, res_parity5;
`endif

  neuron_bank_driver #(.CONNECTIONS(2), .NEURONS(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .nrn_enable(nrn_en1), .nrn_in(nrn_in1), .nrn_out(nrn_out1), .res_valid(res_valid1),
    .res_ready(res_ready1), .res_data(res_data1), .busy(busy1)
`ifdef NRN_DRV_PARITY_EN
    , .res_parity(res_parity1)
`endif
  );

  neuron_bank_driver #(.CONNECTIONS(2), .NEURONS(4), .SETTLE(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .nrn_enable(nrn_en5), .nrn_in(nrn_in5), .nrn_out(nrn_out5), .res_valid(res_valid5),
    .res_ready(res_ready5), .res_data(res_data5), .busy(busy5)
`ifdef NRN_DRV_PARITY_EN
    , .res_parity(res_parity5)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Neuron fires only when no input is active.
  function automatic logic [3:0] exp_res(input logic [1:0] p);
    int s;
    s = int'(p[0]) + int'(p[1]);
    return (s >= 1) ? 4'b0000 : 4'b1111;
  endfunction

  always_comb nrn_out1 = nrn_en1 ? exp_res(nrn_in1) : 4'b0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_in_ready"},  32'(in_ready1),  32'd1);
    check({tag, "_enable"},    32'(nrn_en1),    32'd0);
    check({tag, "_nrn_in"},    32'(nrn_in1),    32'd0);
    check({tag, "_res_valid"}, 32'(res_valid1), 32'd0);
    check({tag, "_res_data"},  32'(res_data1),  32'd0);
    check({tag, "_busy"},      32'(busy1),      32'd0);
`ifdef NRN_DRV_PARITY_EN
    check({tag, "_parity"},    32'(res_parity1), 32'd0);
`endif
  endtask

  // One transaction on dut1 with bp cycles of result backpressure.
  task automatic send1(input logic [1:0] pat, input int bp);
    logic [3:0] exp;
    exp        = exp_res(pat);
    in_valid1  = 1'b1;
    in_data1   = pat;
    res_ready1 = (bp == 0);
    tick();
    in_valid1 = 1'b0;
    in_data1  = 2'($urandom);
    check("drv_enable",   32'(nrn_en1),    32'd1);
    check("drv_nrn_in",   32'(nrn_in1),    32'(pat));
    check("drv_in_ready", 32'(in_ready1),  32'd0);
    check("drv_res_vld",  32'(res_valid1), 32'd0);
    tick();
    check("cap_res_valid", 32'(res_valid1), 32'd1);
    check("cap_res_data",  32'(res_data1),  32'(exp));
    check("cap_enable",    32'(nrn_en1),    32'd0);
`ifdef NRN_DRV_PARITY_EN
    check("cap_parity",    32'(res_parity1), 32'(^exp));
`endif
    for (int i = 0; i < bp; i++) begin
      in_valid1 = 1'($urandom);
      in_data1  = 2'($urandom);
      tick();
      check("bp_res_valid", 32'(res_valid1), 32'd1);
      check("bp_res_data",  32'(res_data1),  32'(exp));
      check("bp_in_ready",  32'(in_ready1),  32'd0);
      check("bp_busy",      32'(busy1),      32'd1);
    end
    in_valid1  = 1'b0;
    res_ready1 = 1'b1;
    tick();
    check("rel_res_valid", 32'(res_valid1), 32'd0);
    check("rel_in_ready",  32'(in_ready1),  32'd1);
    check("rel_busy",      32'(busy1),      32'd0);
  endtask

  logic [1:0] pats[$];
  logic [3:0] got[$];
  int         stamps[$];
  int         idx, cyc;
  logic       acc;
  logic [3:0] v5;
  logic [1:0] p5;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_reset1("rst");
    check("rst5_in_ready", 32'(in_ready5), 32'd1);
    check("rst5_enable",   32'(nrn_en5),   32'd0);
    rst = 1'b0;

    send1(2'b00, 0);
    send1(2'b01, 0);
    send1(2'b00, 10);
    send1(2'($urandom), 3);

    // Reset during DRIVE.
    in_valid1 = 1'b1; in_data1 = 2'b10; res_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("rstd_pre_enable", 32'(nrn_en1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset1("rst_drive");

    // Reset during HOLD with a pending result.
    in_valid1 = 1'b1; in_data1 = 2'b00; res_ready1 = 1'b0;
    tick();
    in_valid1 = 1'b0;
    tick();
    check("rsth_pre_valid", 32'(res_valid1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset1("rst_hold");
    send1(2'b11, 0);

    // Settle window of 5 with nrn_out changing until the capture edge.
    p5        = 2'($urandom);
    v5        = 4'($urandom);
    in_valid5 = 1'b1;
    in_data5  = p5;
    tick();
    in_valid5 = 1'b0;
    check("s5_nrn_in", 32'(nrn_in5), 32'(p5));
    for (int k = 1; k <= 5; k++) begin
      check("s5_enable_hi", 32'(nrn_en5),    32'd1);
      check("s5_res_low",   32'(res_valid5), 32'd0);
      nrn_out5 = (k == 5) ? v5 : ~v5;
      tick();
    end
    nrn_out5 = 4'($urandom);
    check("s5_enable_lo",  32'(nrn_en5),    32'd0);
    check("s5_res_valid",  32'(res_valid5), 32'd1);
    check("s5_res_data",   32'(res_data5),  32'(v5));
`ifdef NRN_DRV_PARITY_EN
    check("s5_parity",     32'(res_parity5), 32'(^v5));
`endif
    res_ready5 = 1'b1;
    tick();
    check("s5_idle", 32'(in_ready5), 32'd1);

    // Streaming with both handshakes held high.
    pats.push_back(2'b00); pats.push_back(2'b01);
    pats.push_back(2'b10); pats.push_back(2'b11);
    for (int i = 0; i < 4; i++) pats.push_back(2'($urandom));
    idx = 0; cyc = 0;
    in_data1 = pats[0]; in_valid1 = 1'b1; res_ready1 = 1'b1;
    while (got.size() < pats.size() && cyc < 100) begin
      if (res_valid1) begin
        got.push_back(res_data1);
        stamps.push_back(cyc);
      end
      acc = in_ready1 && in_valid1;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < pats.size()) in_data1 = pats[idx];
        else in_valid1 = 1'b0;
      end
    end
    check("stream_count", 32'(got.size()), 32'(pats.size()));
    for (int i = 0; i < got.size(); i++) begin
      check("stream_data", 32'(got[i]), 32'(exp_res(pats[i])));
      if (i > 0) check("stream_spacing", 32'(stamps[i] - stamps[i-1]), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_bank_driver.md
Name: neuron_bank_driver

Overview:
- Sequencing front/back end for a bank of combinational threshold neurons. It is the producer of their `enable`/`in` signals and the consumer of their `out` bits.
- Accepts input patterns over a valid/ready handshake and drives them onto the shared neuron input bus.
- Waits a programmable settle time, then captures the bank's output bits into a register.
- Presents the captured result over a second valid/ready handshake to the downstream layer or host.

Parameters:
- CONNECTIONS, 2, width of the input pattern (inputs per neuron).
- NEURONS, 4, number of neurons in the driven bank (result width).
- SETTLE, 1, cycles `nrn_enable` is held before capture; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input pattern valid
- in_ready  out  1  driver can accept a pattern
- in_data  in  CONNECTIONS  input pattern
- nrn_enable  out  1  enable to every neuron in the bank
- nrn_in  out  CONNECTIONS  registered pattern broadcast to the bank
- nrn_out  in  NEURONS  neuron output bits, one per neuron
- res_valid  out  1  captured result valid
- res_ready  in  1  downstream accepts result
- res_data  out  NEURONS  captured neuron outputs
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states are IDLE, DRIVE, HOLD. Reset enters IDLE.
- Reset values: in_ready=1, nrn_enable=0, nrn_in=0, res_valid=0, res_data=0, busy=0, settle counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: nrn_in<=in_data, nrn_enable<=1, counter<=SETTLE-1, go to DRIVE.
- DRIVE:
  - in_ready=0.
  - Counter decrements each edge.
  - At the edge where counter==0: res_data<=nrn_out, res_valid<=1, nrn_enable<=0, go to HOLD.
  - Capture therefore occurs at edge T+SETTLE, and res_valid is first seen high in the cycle after T+SETTLE.
  - nrn_enable is high for exactly SETTLE cycles.
- HOLD:
  - res_valid=1; res_data is stable until accepted; nrn_in keeps its last value; nrn_enable=0.
  - On res_valid&res_ready: res_valid<=0, go to IDLE.
  - in_ready stays 0 in HOLD, so there is one bubble cycle between results. This is intentional.
- Signals ignored in each state: in_data/in_valid outside IDLE; nrn_out outside the capture edge; res_ready outside HOLD.
- Reset asserted in any state returns the block to IDLE with reset values on the next edge. A pending result is discarded.
- in_valid held high continuously: patterns are accepted every SETTLE+2 cycles, provided res_ready is also held high.
- Counter width is 8 bits. SETTLE=0 or SETTLE>255 is a static configuration error, flagged by a generate-time check.

Optional Feature:
- Macro: NRN_DRV_PARITY_EN.
- With the macro: extra output `res_parity` (1 bit) equal to the XOR of the captured res_data. It is registered on the capture edge and is 0 on reset.
- Without the macro: the port does not exist and no parity logic is present.

Decomposition:
- Shared package nrn_pkg:
  - FSM state typedef {IDLE, DRIVE, HOLD}.
  - Constant SETTLE_MAX=255.
  - Counter width constant, 8.
- One sub-module, nrn_settle_counter: a loadable down-counter with a zero flag. The FSM and capture register stay in the top block.

Test Plan:
All scenarios use CONNECTIONS=2, NEURONS=4, SETTLE=1, with the bench modelling each neuron as out = enable ? (in0+in1>=1 ? 0 : 1) : 0.
1. Basic pattern 0: in_data=2'b00 accepted at edge T, res_ready=1 → nrn_enable high for one cycle; res_data=4'b1111 with res_valid rising after edge T+1; res_valid drops after the handshake.
2. Basic pattern 1: in_data=2'b01 → res_data=4'b0000. With NRN_DRV_PARITY_EN, res_parity=0; for test 1, res_parity=0.
3. Backpressure: res_ready=0 for 10 cycles after capture → res_valid and res_data stay stable, in_ready=0 and busy=1 throughout; res_ready pulsed → IDLE the next cycle.
4. Settle length: SETTLE=5 → nrn_enable high exactly 5 cycles; capture at edge T+5; bench changes nrn_out mid-window, and only the value at T+5 appears in res_data.
5. Mid-operation reset: rst asserted during DRIVE, and separately during HOLD → next cycle all outputs equal their reset values and in_ready=1; the next pattern, 2'b11, produces res_data=4'b0000 normally.
6. Streaming: in_valid and res_ready held high, patterns 00, 01, 10, 11 → four results 1111, 0000, 0000, 0000 in order, spaced SETTLE+2=3 cycles apart.
